water_flow_monitor: RTL and testbench
=====================================

Name: water_flow_monitor

Overview:
Watches water-level progress while the washer FSM fills or drains the drum. It raises water_flow_error when the level fails to move in the commanded direction for too long. It sits beside the washer FSM: it consumes that FSM's water_flow_mode and water_flow_reset, and its water_flow_error output feeds the FSM's water_flow_error input. It samples the same water_level_sensor bus the FSM uses.

Parameters:
LEVEL_W, 10, width of water_level_sensor
CHECK_PERIOD, 1000, clock cycles per progress window (>=2)
MIN_DELTA, 2, minimum level change per window counted as progress (>=1)
MAX_STALL_WINDOWS, 3, consecutive failing windows before error (1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
water_flow_reset  input  1  synchronous clear/idle request from FSM; 1 = monitor idle
water_flow_mode  input  1  1 = filling, 0 = draining; ignored while water_flow_reset=1
water_level_sensor  input  LEVEL_W  current drum water level
water_flow_error  output  1  sticky flow fault to FSM
monitor_active  output  1  1 while in ARM or MONITOR
stall_count  output  4  consecutive failing windows so far

Behaviour:
- Reset (reset=0, async): state=IDLE, water_flow_error=0, monitor_active=0, stall_count=0, window counter=0, baseline=0, latched mode=0.
- All outputs are registered. Next-state decode is combinational; every output change appears at the clock edge after the triggering condition.
- States: IDLE, ARM, MONITOR, ERROR.
- water_flow_reset=1 forces IDLE from any state on the next edge. It also clears the error, stall_count and window counter. It has priority over every other condition.
- IDLE -> ARM when water_flow_reset=0.
- ARM, 1 cycle: latch water_flow_mode and baseline=water_level_sensor; window counter=0; -> MONITOR. monitor_active=1.
- MONITOR: window counter increments each cycle. Terminal cycle is counter==CHECK_PERIOD-1; on it the counter wraps to 0 and progress is evaluated:
  - Fill progress: water_level_sensor >= baseline+MIN_DELTA, computed at LEVEL_W+1 bits with no wrap; or level == all-ones (full scale).
  - Drain progress: water_level_sensor == 0; or (baseline >= MIN_DELTA and level <= baseline-MIN_DELTA).
  - On progress: stall_count=0, baseline=current level.
  - On no progress: stall_count+1, baseline unchanged.
  - If the incremented stall_count equals MAX_STALL_WINDOWS: -> ERROR, water_flow_error=1 on the same edge.
- Mode change: if water_flow_mode differs from the latched mode while in MONITOR, go to ARM (re-baseline). stall_count and window counter are cleared. No error is raised.
- ERROR: water_flow_error=1, monitor_active=0, stall_count holds. The state is sticky until water_flow_reset=1. Level recovery does not clear it.
- Simultaneous events:
  - water_flow_reset beats everything.
  - A mode change beats a terminal-cycle evaluation in the same cycle.
- Drain held at 0 never accumulates stalls. Fill held at full scale never accumulates stalls.
- With default parameters, the first evaluation happens CHECK_PERIOD cycles after entering MONITOR. The error is visible CHECK_PERIOD*MAX_STALL_WINDOWS + 2 cycles after water_flow_reset falls.
- No level filtering: the sensor is sampled raw on terminal cycles only.

Optional Feature:
WFM_REVERSE_FLOW_EN
- Defined: in MONITOR, on any cycle (not only terminal), the block flags reverse flow and goes -> ERROR with water_flow_error=1 on the next edge:
  - filling and level + MIN_DELTA < baseline (checked at LEVEL_W+1 bits), or
  - draining and level > baseline+MIN_DELTA.
  - stall_count is unchanged. water_flow_reset and mode-change priorities still apply.
- Undefined: no reverse-flow check. A level moving the wrong way is only caught as lack of progress via stall windows.

Test Plan (CHECK_PERIOD=8, MIN_DELTA=2, MAX_STALL_WINDOWS=3, LEVEL_W=10):
1. Assert reset=0 mid-MONITOR with stall_count=2 -> all outputs 0 immediately, without waiting for clk. Release -> IDLE.
2. Fill mode, water_flow_reset falls, level ramps 10->12->14 in steps of 2 per window -> stall_count stays 0, water_flow_error stays 0 across 10 windows.
3. Fill mode, level held at 50 -> stall_count 1,2 at ends of windows 1,2. water_flow_error=1 at the end of window 3, 26 cycles after water_flow_reset fell. Level later rising to 200 keeps error=1. water_flow_reset=1 clears it next edge.
4. Drain mode, baseline 1, level stays 1 -> no progress, since baseline < MIN_DELTA and level != 0. Level reaches 0 -> stall_count=0 at next terminal. Level held at 0 for 5 windows -> no error.
5. MONITOR with stall_count=2, flip water_flow_mode on a terminal cycle -> ARM next edge, stall_count=0, no error, new baseline = current level.
6. With WFM_REVERSE_FLOW_EN, fill baseline 100, level drops to 97 mid-window -> water_flow_error=1 next edge. Without the macro, same stimulus -> error only after 3 windows.

Source files
------------

// File: rtl/water_flow_monitor.sv
// Flags a stalled fill or drain: the drum level must move by MIN_DELTA in the commanded
// direction every CHECK_PERIOD cycles. Optional immediate reverse-flow trip: WFM_REVERSE_FLOW_EN.
module water_flow_monitor #(
    parameter int LEVEL_W           = 10,
    parameter int CHECK_PERIOD      = 1000,
    parameter int MIN_DELTA         = 2,
    parameter int MAX_STALL_WINDOWS = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               water_flow_reset,
    input  logic               water_flow_mode,
    input  logic [LEVEL_W-1:0] water_level_sensor,
    output logic               water_flow_error,
    output logic               monitor_active,
    output logic [3:0]         stall_count,
    output logic [1:0]         state_dbg
);

    localparam int                 CNT_W     = $clog2(CHECK_PERIOD);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(CHECK_PERIOD - 1);
    localparam logic [LEVEL_W:0]   DELTA_X   = (LEVEL_W + 1)'(MIN_DELTA);
    localparam logic [3:0]         STALL_MAX = 4'(MAX_STALL_WINDOWS);

    typedef enum logic [1:0] {IDLE, ARM, MONITOR, ERROR} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEVEL_W-1:0] base_q, base_d;
    logic               mode_q, mode_d;
    logic [3:0]         stall_q, stall_d;
    logic               err_q, err_d;
    logic               active_q, active_d;

    logic [LEVEL_W:0]   level_x, base_x;
    logic [3:0]         stall_inc;
    logic               fill_prog, drain_prog, progress, terminal, reverse;

    // Progress arithmetic is done one bit wider so baseline+MIN_DELTA cannot wrap.
    assign level_x    = {1'b0, water_level_sensor};
    assign base_x     = {1'b0, base_q};
    assign stall_inc  = stall_q + 4'd1;
    assign terminal   = (cnt_q == CNT_LAST);
    assign fill_prog  = (level_x >= base_x + DELTA_X) || (water_level_sensor == {LEVEL_W{1'b1}});
    assign drain_prog = (water_level_sensor == '0) ||
                        ((base_x >= DELTA_X) && (level_x <= base_x - DELTA_X));
    assign progress   = mode_q ? fill_prog : drain_prog;

`ifdef WFM_REVERSE_FLOW_EN
    assign reverse = mode_q ? (level_x + DELTA_X < base_x) : (level_x > base_x + DELTA_X);
`else
    assign reverse = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        mode_d  = mode_q;
        stall_d = stall_q;
        err_d   = err_q;
        if (water_flow_reset) begin
            state_d = IDLE;
            err_d   = 1'b0;
            stall_d = 4'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: state_d = ARM;
                ARM: begin
                    mode_d  = water_flow_mode;
                    base_d  = water_level_sensor;
                    cnt_d   = '0;
                    state_d = MONITOR;
                end
                MONITOR: begin
                    if (water_flow_mode != mode_q) begin
                        // Direction changed: re-baseline without blaming the old window.
                        state_d = ARM;
                        stall_d = 4'd0;
                        cnt_d   = '0;
                    end else if (reverse) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else if (terminal) begin
                        cnt_d = '0;
                        if (progress) begin
                            stall_d = 4'd0;
                            base_d  = water_level_sensor;
                        end else begin
                            stall_d = stall_inc;
                            if (stall_inc == STALL_MAX) begin
                                state_d = ERROR;
                                err_d   = 1'b1;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ERROR: err_d = 1'b1;
                default: state_d = IDLE;
            endcase
        end
        active_d = (state_d == ARM) || (state_d == MONITOR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            base_q   <= '0;
            mode_q   <= 1'b0;
            stall_q  <= 4'd0;
            err_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            mode_q   <= mode_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
            active_q <= active_d;
        end
    end

    assign water_flow_error = err_q;
    assign monitor_active   = active_q;
    assign stall_count      = stall_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_water_flow_monitor.sv
// Directed bench for water_flow_monitor with CHECK_PERIOD=8, MIN_DELTA=2, MAX_STALL_WINDOWS=3.
module tb_water_flow_monitor;

    localparam logic [1:0] S_IDLE = 2'd0, S_ARM = 2'd1, S_MON = 2'd2, S_ERR = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic       water_flow_reset;
    logic       water_flow_mode;
    logic [9:0] water_level_sensor;
    logic       water_flow_error;
    logic       monitor_active;
    logic [3:0] stall_count;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    water_flow_monitor #(
        .LEVEL_W(10), .CHECK_PERIOD(8), .MIN_DELTA(2), .MAX_STALL_WINDOWS(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .water_flow_reset(water_flow_reset),
        .water_flow_mode(water_flow_mode),
        .water_level_sensor(water_level_sensor),
        .water_flow_error(water_flow_error),
        .monitor_active(monitor_active),
        .stall_count(stall_count),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; returns 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Idle the monitor for one edge, then release it in the given mode/level.
    task automatic start(input logic mode, input logic [9:0] level);
        water_flow_reset = 1'b1;
        tick(1);
        water_flow_mode    = mode;
        water_level_sensor = level;
        water_flow_reset   = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        water_flow_reset = 1'b1;
        water_flow_mode = 1'b0;
        water_level_sensor = '0;
        #1;
        check("rst_err", water_flow_error, 0);
        check("rst_active", monitor_active, 0);
        check("rst_stall", stall_count, 0);
        check("rst_state", state_dbg, S_IDLE);
        tick(2);
        reset = 1'b1;
        tick(1);

        // Fill ramp of +2 per window: always progress.
        start(1'b1, 10'd10);
        tick(1);
        check("ramp_arm_state", state_dbg, S_ARM);
        check("ramp_arm_active", monitor_active, 1);
        tick(1);
        check("ramp_mon_state", state_dbg, S_MON);
        for (int k = 0; k < 10; k++) begin
            water_level_sensor = 10'(10 + 2 * (k + 1));
            tick(8);
            check("ramp_stall", stall_count, 0);
            check("ramp_err", water_flow_error, 0);
        end
        water_flow_reset = 1'b1;
        tick(1);
        check("ramp_idle_state", state_dbg, S_IDLE);
        check("ramp_idle_active", monitor_active, 0);

        // Fill held at 50: error 26 cycles after release.
        start(1'b1, 10'd50);
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        tick(2);
        tick(8);
        check("hold_w1_stall", stall_count, exp_q.pop_front());
        tick(8);
        check("hold_w2_stall", stall_count, exp_q.pop_front());
        tick(7);
        check("hold_pre_err", water_flow_error, 0);
        tick(1);
        check("hold_err", water_flow_error, 1);
        check("hold_err_stall", stall_count, 3);
        check("hold_err_active", monitor_active, 0);
        check("hold_err_state", state_dbg, S_ERR);
        water_level_sensor = 10'd200;
        tick(10);
        check("sticky_err", water_flow_error, 1);
        check("sticky_stall", stall_count, 3);
        water_flow_reset = 1'b1;
        tick(1);
        check("clr_err", water_flow_error, 0);
        check("clr_stall", stall_count, 0);

        // Drain from baseline 1: stall, then reaching 0 is progress, 0 held never stalls.
        start(1'b0, 10'd1);
        tick(2);
        tick(8);
        check("drain1_stall", stall_count, 1);
        water_level_sensor = 10'd0;
        tick(8);
        check("drain0_stall", stall_count, 0);
        for (int k = 0; k < 5; k++) begin
            tick(8);
            check("drain0_hold_stall", stall_count, 0);
        end
        check("drain0_err", water_flow_error, 0);

        // Fill held at full scale never stalls.
        start(1'b1, 10'h3FF);
        tick(2);
        for (int k = 0; k < 4; k++) begin
            tick(8);
            check("full_stall", stall_count, 0);
        end
        check("full_err", water_flow_error, 0);

        // Mode flip on a terminal cycle with stall_count=2 beats the third failing window.
        start(1'b1, 10'd300);
        tick(2);
        tick(16);
        check("flip_pre_stall", stall_count, 2);
        tick(7);
        water_flow_mode = 1'b0;
        water_level_sensor = 10'd301;
        tick(1);
        check("flip_state", state_dbg, S_ARM);
        check("flip_stall", stall_count, 0);
        check("flip_err", water_flow_error, 0);
        check("flip_active", monitor_active, 1);
        tick(1);
        check("flip_mon", state_dbg, S_MON);
        // 299 is progress only against the new baseline 301.
        water_level_sensor = 10'd299;
        tick(8);
        check("flip_rebase_stall", stall_count, 0);

        // Fill baseline 100, level drops to 97 mid-window.
        start(1'b1, 10'd100);
        tick(2);
        tick(3);
        water_level_sensor = 10'd97;
        tick(1);
`ifdef WFM_REVERSE_FLOW_EN
        check("rev_err", water_flow_error, 1);
        check("rev_stall", stall_count, 0);
        check("rev_state", state_dbg, S_ERR);
`else
        check("norev_err_early", water_flow_error, 0);
        tick(19);
        check("norev_pre_err", water_flow_error, 0);
        check("norev_pre_stall", stall_count, 2);
        tick(1);
        check("norev_err", water_flow_error, 1);
        check("norev_stall", stall_count, 3);
`endif

        // Async reset mid-MONITOR with stall_count=2.
        start(1'b1, 10'd500);
        tick(18);
        check("ar_pre_stall", stall_count, 2);
        check("ar_pre_active", monitor_active, 1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_err", water_flow_error, 0);
        check("ar_active", monitor_active, 0);
        check("ar_stall", stall_count, 0);
        check("ar_state", state_dbg, S_IDLE);
        reset = 1'b1;
        water_flow_reset = 1'b1;
        tick(1);
        check("ar_rel_state", state_dbg, S_IDLE);
        water_flow_reset = 1'b0;
        tick(1);
        check("ar_rel_arm", state_dbg, S_ARM);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
